snake_step_scheduler: RTL
=========================

# snake_step_scheduler

Paces and steers the snake in the FPGA snake game. It sits between the game-status FSM and the snake body/collision datapath. It arbitrates the on-board buttons and the PS/2 keyboard direction strobes into one committed direction, rejects 180° reversals, and issues a one-cycle `move_tick` at the current game speed. Each `eat` pulse shortens the step period down to a floor.

## Interface
Parameters:
- `CNT_W`, 28: width of step counter and period register.
- `BASE_PERIOD`, 25_000_000: clock cycles per step after init (4 steps/s at 100 MHz).
- `MIN_PERIOD`, 5_000_000: period floor.
- `STEP_DEC`, 1_000_000: period reduction per effective `eat`.

Ports:
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `game_status`  in  2  from game FSM: 00 PAUSED, 01 PLAYING, 10 DIE_FLASHING, 11 INITIALIZING.
- `up`, `right`, `down`, `left`  in  1 each  debounced button pulses/levels.
- `kup`, `kright`, `kdown`, `kleft`  in  1 each  keyboard direction strobes.
- `eat`  in  1  one-cycle pulse from datapath: head reached food.
- `dir`  out  2  committed direction: 00 up, 01 right, 10 down, 11 left.
- `move_tick`  out  1  registered one-cycle step strobe.
- `speed_level`  out  4  number of effective speed-ups, saturating at 15.

## Operation
- Internal registers: `count` (CNT_W), `period` (CNT_W), `pending` (2), plus the outputs.
- Reset, or any cycle with `game_status`=11 (INITIALIZING):
  - `count`=0, `period`=BASE_PERIOD, `dir`=01, `speed_level`=0, `move_tick`=0.
  - `pending`=01 on reset. While INITIALIZING, `pending` may still accept a request (see arbitration), so the starting key press steers the first step.
- PLAYING (01):
  - `count` increments each cycle.
  - When `count` >= `period`-1: next edge sets `move_tick`=1, `count`=0, `dir`=`pending`.
  - Otherwise `move_tick`=0.
- PAUSED (00): `count`, `period`, `dir` and `speed_level` hold. `move_tick`=0. Requests are still accepted into `pending`.
- DIE_FLASHING (10): everything holds, `move_tick`=0, requests are ignored.
- Arbitration (combinational request, registered into `pending`):
  - Buttons beat keyboard.
  - Within a group: up > right > down > left.
  - One winner per cycle. No request leaves `pending` unchanged.
- Reversal rejection:
  - Reference direction is `eff` = `pending` if a tick is being issued this edge, else `dir`.
  - A winner equal to `eff` XOR 2'b10 is discarded; `pending` is unchanged.
  - A winner equal to `eff` is accepted (no effect).
- Speed:
  - `eat`=1 in PLAYING: `period` <= max(`period`-STEP_DEC, MIN_PERIOD).
  - `speed_level` increments (saturating at 15) only if `period` actually decreased.
  - `eat` outside PLAYING is ignored.
  - `eat` coincident with tick: both take effect. The new period applies to the following step.
- Period shortened below the current `count`: the >= compare fires the tick on the next edge, so no counter wrap-around is possible.
- `period`-1 arithmetic is on CNT_W bits. MIN_PERIOD >= 2 is required. BASE_PERIOD < 2^CNT_W.

## Timing
- All outputs are registered. Reset values: `dir`=01, `move_tick`=0, `speed_level`=0.
- Entering PLAYING from INITIALIZING (`count`=0): first `move_tick` is high on the `period`-th cycle of PLAYING, then every `period` cycles.
- `dir` changes on the same edge that raises `move_tick`. The datapath samples `dir` while `move_tick`=1.
- Request to `pending`: 1 cycle. `pending` to `dir`: at the next tick.
- Only one direction change per step. The last accepted request before the tick wins.
- Pause then resume: the tick fires `period`-1-`count_held` cycles after returning to PLAYING. No tick is lost or duplicated.
- `reset` dominates every input in the same cycle. A mid-step reset drops any pending tick.

## Test plan
Bench parameters: BASE_PERIOD=10, MIN_PERIOD=4, STEP_DEC=3.
- Reset, then `game_status` 11 for 3 cycles, then 01 → `move_tick` pulses at PLAYING cycles 10, 20, 30. `dir` stays 01. Each pulse is exactly 1 cycle wide.
- With `dir`=01, pulse `kleft` → next tick `dir` stays 01. Pulse `up` → next tick `dir`=00. Then pulse `down` → rejected, `dir` stays 00.
- `up` and `kdown` asserted in the same cycle → `pending`=00. `down` and `left` asserted together with `dir`=01 → `pending`=10.
- Three `eat` pulses in PLAYING → `period` 10→7→4→4, `speed_level` 0→1→2→2. `eat` while PAUSED → no change.
- `count`=6 in PLAYING, `game_status`=00 for 50 cycles, then 01 → no tick while paused. Tick on the 4th cycle after resume.
- Mid-run with `period`=4, `dir`=10, `speed_level`=2, drive `game_status`=11 for 1 cycle, then `reset` on a tick cycle → `period`=10, `dir`=01, `speed_level`=0, `move_tick`=0 next cycle.

Source files
------------

// File: rtl/snake_step_scheduler.sv
// -----------------------------------------------------------------------------
// snake_step_scheduler
//
// Sets the pace of the snake and decides which way it turns. The block sits
// between the game-status FSM and the snake body/collision datapath. It
// arbitrates the on-board buttons and the PS/2 keyboard direction strobes
// into one committed direction, and it refuses 180-degree reversals. It
// issues a one-cycle move_tick at the current game speed. Each effective
// eat pulse shortens the step period, down to a floor.
//
// Parameters
//   CNT_W        width of the step counter and the period register
//   BASE_PERIOD  clock cycles per step after initialisation
//   MIN_PERIOD   lowest allowed step period (must be >= 2)
//   STEP_DEC     period reduction for each effective eat
//
// Ports
//   clock                      system clock; all logic runs on the rising edge
//   reset                      synchronous, active-high
//   game_status[1:0]           00 PAUSED, 01 PLAYING, 10 DIE_FLASHING,
//                              11 INITIALIZING
//   up/right/down/left         debounced button requests (highest priority group)
//   kup/kright/kdown/kleft     keyboard direction strobes
//   eat                        one-cycle pulse: the head reached the food
//   dir[1:0]                   committed direction: 00 up, 01 right, 10 down,
//                              11 left
//   move_tick                  registered one-cycle step strobe
//   speed_level[3:0]           number of effective speed-ups, saturates at 15
// -----------------------------------------------------------------------------
module snake_step_scheduler #(
  parameter int CNT_W       = 28,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int MIN_PERIOD  = 5_000_000,
  parameter int STEP_DEC    = 1_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       game_status,
  input  logic             up,
  input  logic             right,
  input  logic             down,
  input  logic             left,
  input  logic             kup,
  input  logic             kright,
  input  logic             kdown,
  input  logic             kleft,
  input  logic             eat,
  output logic [1:0]       dir,
  output logic             move_tick,
  output logic [3:0]       speed_level
);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_PLAYING = 2'b01,
    ST_DYING   = 2'b10,
    ST_INIT    = 2'b11
  } status_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] DEC_P  = CNT_W'(STEP_DEC);
  localparam logic [CNT_W-1:0] ONE_P  = CNT_W'(1);
  // One extra bit so that floor + decrement cannot overflow the compare.
  localparam logic [CNT_W:0]   SHRINK_LIMIT = (CNT_W+1)'(MIN_PERIOD + STEP_DEC);

  status_e          status;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic [1:0]       pending;

  logic             playing;
  logic             tick_now;
  logic             req_valid;
  logic [1:0]       req_dir;
  logic [1:0]       eff_dir;
  logic             accept;
  logic             can_shrink;
  logic [CNT_W-1:0] shrunk_period;

  assign status  = status_e'(game_status);
  assign playing = (status == ST_PLAYING);

  // The step ends when count reaches period-1. The >= compare also fires
  // at once if an eat has just pulled the period below the running count.
  // This keeps the counter from ever wrapping.
  assign tick_now = playing && (count >= (period - ONE_P));

  // ---------------------------------------------------------------------------
  // Request arbitration: buttons beat keyboard; up > right > down > left.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the if-chain leaves a value unassigned and no latch is inferred.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if      (up)     req_dir = DIR_UP;
    else if (right)  req_dir = DIR_RIGHT;
    else if (down)   req_dir = DIR_DOWN;
    else if (left)   req_dir = DIR_LEFT;
    else if (kup)    req_dir = DIR_UP;
    else if (kright) req_dir = DIR_RIGHT;
    else if (kdown)  req_dir = DIR_DOWN;
    else if (kleft)  req_dir = DIR_LEFT;
    else             req_valid = 1'b0;
  end

  // On a tick edge, pending becomes the new heading. A request in that same
  // cycle is therefore judged against pending and not against the outgoing dir.
  assign eff_dir = tick_now ? pending : dir;

  // Requests are frozen while the death animation plays. Flipping bit 1 of a
  // direction gives its opposite, which is a reversal and is dropped.
  assign accept = req_valid
               && (status != ST_DYING)
               && (req_dir != (eff_dir ^ 2'b10));

  // ---------------------------------------------------------------------------
  // Speed-up arithmetic
  // ---------------------------------------------------------------------------
  assign can_shrink    = (period > MIN_P);
  assign shrunk_period = ({1'b0, period} > SHRINK_LIMIT) ? (period - DEC_P) : MIN_P;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only. Every right-hand
  // side then sees the pre-edge values, so the block has no ordering
  // dependence.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it is sampled here like any other input
    // and it takes priority over every other input in the same cycle.
    if (reset) begin
      count       <= '0;
      period      <= BASE_P;
      pending     <= DIR_RIGHT;
      dir         <= DIR_RIGHT;
      speed_level <= 4'd0;
      move_tick   <= 1'b0;
    end else begin
      move_tick <= tick_now;

      if (accept) begin
        pending <= req_dir;
      end

      case (status)
        ST_INIT: begin
          count       <= '0;
          period      <= BASE_P;
          dir         <= DIR_RIGHT;
          speed_level <= 4'd0;
        end

        ST_PLAYING: begin
          if (tick_now) begin
            count <= '0;
            dir   <= pending;
          end else begin
            count <= count + ONE_P;
          end

          // An eat on a tick edge still counts. The shorter period then
          // governs the step that starts on this edge.
          if (eat && can_shrink) begin
            period <= shrunk_period;
            if (speed_level != 4'hF) begin
              speed_level <= speed_level + 4'd1;
            end
          end
        end

        // PAUSED and DIE_FLASHING hold the step counter, period, dir and level.
        default: begin
        end
      endcase
    end
  end

endmodule
